// File: rtl/ahb_mem_wait_param.sv
// AHB-Lite slave RAM with separate read/write wait-state counts and a 2-cycle ERROR response.
// Latency: a valid data phase lasts N+1 cycles after the accept edge (N = READ_WAIT or WRITE_WAIT); an error lasts 2 cycles.
// Backpressure: HREADYOUT is held low for the N wait cycles or the first error cycle; a new address phase is taken in IDLE/LAST/ERR2.
//
// Ports:
//   HCLK, HRESETn          clock (rising edge), asynchronous active-low reset
//   HSEL, HADDR, HSIZE,    address-phase controls; HSIZE 0/1/2 = byte/halfword/word
//   HWRITE, HTRANS, HREADY
//   HWDATA                 write data, sampled in the LAST cycle of a write
//   HRDATA                 full read word during LAST of a read, zero otherwise
//   HREADYOUT, HRESP       data-phase done, 0 OKAY / 1 ERROR
module ahb_mem_wait_param #(
   parameter int DEPTH_WORDS = 16384,
   parameter int READ_WAIT   = 3,
   parameter int WRITE_WAIT  = 1
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [1:0]  HTRANS,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

   localparam int         AW   = $clog2(DEPTH_WORDS);
   localparam logic [3:0] RD_N = 4'(READ_WAIT);
   localparam logic [3:0] WR_N = 4'(WRITE_WAIT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_LAST,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t        state, state_d;
   logic [3:0]    cnt, cnt_d;
   logic [AW-1:0] addr_q;
   logic [3:0]    be_q;
   logic          wr_q;

   // Not reset: contents are undefined until written.
   logic [31:0]   mem [DEPTH_WORDS];

   logic          can_accept;
   logic          accept;
   logic          in_range;
   logic          size_ok;
   logic          aligned;
   logic          acc_valid;
   logic [3:0]    be_d;
   logic [3:0]    n_wait;

   // WAIT/ERR1 hold HREADY low bus-wide anyway; gating here keeps a
   // misbehaving HREADY from corrupting an in-flight data phase.
   assign can_accept = (state == ST_IDLE) || (state == ST_LAST) || (state == ST_ERR2);
   assign accept     = HSEL & HREADY & HTRANS[1] & can_accept;

   // Any bit set above the byte-address range means out of range.
   assign in_range   = (HADDR >> (AW + 2)) == 32'd0;
   assign acc_valid  = in_range & size_ok & aligned;
   assign n_wait     = HWRITE ? WR_N : RD_N;

   // Little-endian byte lanes and alignment rules per transfer size.
   always_comb begin
      size_ok = 1'b1;
      aligned = 1'b1;
      be_d    = 4'b0000;
      case (HSIZE)
         3'd0: be_d = 4'b0001 << HADDR[1:0];
         3'd1: begin
            aligned = ~HADDR[0];
            be_d    = HADDR[1] ? 4'b1100 : 4'b0011;
         end
         3'd2: begin
            aligned = (HADDR[1:0] == 2'b00);
            be_d    = 4'b1111;
         end
         default: size_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         ST_WAIT: begin
            if (cnt == 4'd0) begin
               state_d = ST_LAST;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            // IDLE, LAST and ERR2 all overlap a possible new address phase.
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            if (accept) begin
               if (!acc_valid) begin
                  state_d = ST_ERR1;
               end else if (n_wait != 4'd0) begin
                  state_d = ST_WAIT;
                  cnt_d   = n_wait - 4'd1;
               end else begin
                  state_d = ST_LAST;
               end
            end
         end
      endcase
   end

   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      HRDATA    = 32'd0;
      case (state)
         ST_WAIT: HREADYOUT = 1'b0;
         ST_LAST: begin
            if (!wr_q) begin
               HRDATA = mem[addr_q];
            end
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
         end
         ST_ERR2: HRESP = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state  <= ST_IDLE;
         cnt    <= 4'd0;
         addr_q <= '0;
         be_q   <= 4'd0;
         wr_q   <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         if (accept) begin
            addr_q <= HADDR[AW+1:2];
            be_q   <= be_d;
            wr_q   <= HWRITE;
         end
      end
   end

   // Commit happens on the edge that ends LAST, so HWDATA is the value the
   // master holds in the final data-phase cycle. A reset forces IDLE first,
   // which drops any write still in WAIT.
   always_ff @(posedge HCLK) begin
      if (state == ST_LAST && wr_q) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
               mem[addr_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_mem_wait_param.sv
module tb_ahb_mem_wait_param;

   localparam int DEPTH_A = 1024;
   localparam int RW_A    = 3;
   localparam int WW_A    = 1;
   localparam int DEPTH_B = 64;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel_a, hsel_b;
   logic [31:0] haddr, hwdata;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [1:0]  htrans;
   logic [31:0] hrdata_a, hrdata_b;
   logic        hreadyout_a, hreadyout_b, hresp_a, hresp_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 hclk = ~hclk;

   ahb_mem_wait_param #(.DEPTH_WORDS(DEPTH_A), .READ_WAIT(RW_A), .WRITE_WAIT(WW_A)) u_dut_a (
      .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_a), .HADDR(haddr), .HSIZE(hsize),
      .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hreadyout_a), .HTRANS(htrans),
      .HRDATA(hrdata_a), .HREADYOUT(hreadyout_a), .HRESP(hresp_a)
   );

   ahb_mem_wait_param #(.DEPTH_WORDS(DEPTH_B), .READ_WAIT(0), .WRITE_WAIT(0)) u_dut_b (
      .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_b), .HADDR(haddr), .HSIZE(hsize),
      .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hreadyout_b), .HTRANS(htrans),
      .HRDATA(hrdata_b), .HREADYOUT(hreadyout_b), .HRESP(hresp_b)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      bit          exp_err;
      logic [31:0] exp_rdata;
      bit          use_model;
   } vec_t;

   vec_t        xq[$];
   vec_t        tbl[$];
   int          total_cycles;
   logic [31:0] mem_a [int];
   logic [31:0] mem_b [DEPTH_B];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [2:0] s,
                               input logic [31:0] wd, input bit err, input logic [31:0] rd,
                               input bit um);
      vec_t v;
      v.wr = wr; v.addr = a; v.size = s; v.wdata = wd;
      v.exp_err = err; v.exp_rdata = rd; v.use_model = um;
      return v;
   endfunction

   // Reference rules: in range, legal size, naturally aligned.
   function automatic bit valid(input logic [31:0] a, input logic [2:0] s, input int depth);
      if (s > 3'd2) return 1'b0;
      if ((a >> 2) >= 32'(depth)) return 1'b0;
      return (a % (32'd1 << s)) == 32'd0;
   endfunction

   // Replace the (1<<size) bytes starting at byte offset addr%4.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                         input logic [2:0] s, input logic [31:0] wd);
      logic [31:0] r;
      int lane;
      r = old;
      for (int b = 0; b < (1 << s); b++) begin
         lane = int'(a % 4) + b;
         r[lane*8 +: 8] = wd[lane*8 +: 8];
      end
      return r;
   endfunction

   task automatic drive_addr(input vec_t v);
      hsel_a = 1'b1; htrans = 2'b10; haddr = v.addr; hsize = v.size; hwrite = v.wr;
   endtask

   task automatic drive_idle();
      hsel_a = 1'b0; hsel_b = 1'b0; htrans = 2'b00;
   endtask

   // Runs xq back-to-back on DUT A: the next address phase is presented as
   // soon as the current one is accepted and is taken when HREADYOUT rises.
   task automatic run_q();
      vec_t        v;
      bit          e, done;
      logic [31:0] rd;
      int          exp_lows, lows;
      total_cycles = 0;
      drive_addr(xq[0]);
      for (int k = 0; k < xq.size(); k++) begin
         v = xq[k];
         @(posedge hclk); #1;
         hwdata = v.wdata;
         if (k + 1 < xq.size()) drive_addr(xq[k+1]);
         else drive_idle();
         if (v.use_model) begin
            e  = !valid(v.addr, v.size, DEPTH_A);
            rd = 32'd0;
            if (!e && !v.wr && mem_a.exists(int'(v.addr >> 2))) rd = mem_a[int'(v.addr >> 2)];
         end else begin
            e  = v.exp_err;
            rd = v.wr ? 32'd0 : v.exp_rdata;
         end
         exp_lows = e ? 1 : (v.wr ? WW_A : RW_A);
         lows = 0;
         done = 1'b0;
         for (int c = 0; c < 20 && !done; c++) begin
            @(negedge hclk);
            chk("hresp", 32'(hresp_a), 32'(e));
            if (hreadyout_a) begin
               done = 1'b1;
               chk("hrdata_last", hrdata_a, rd);
            end else begin
               lows++;
               chk("hrdata_wait", hrdata_a, 32'd0);
               @(posedge hclk); #1;
            end
         end
         chk("ready_low_cycles", 32'(lows), 32'(exp_lows));
         total_cycles += lows + 1;
         if (v.wr && !e) begin
            if (!mem_a.exists(int'(v.addr >> 2))) mem_a[int'(v.addr >> 2)] = 32'd0;
            mem_a[int'(v.addr >> 2)] = merge(mem_a[int'(v.addr >> 2)], v.addr, v.size, v.wdata);
         end
      end
      @(posedge hclk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      hsel_a = 0; hsel_b = 0; htrans = 0; haddr = 0; hsize = 0; hwrite = 0; hwdata = 0;
      hresetn = 1'b0;
      #12;
      chk("rst_ready_a", 32'(hreadyout_a), 32'd1);
      chk("rst_resp_a",  32'(hresp_a),     32'd0);
      chk("rst_rdata_a", hrdata_a,         32'd0);
      chk("rst_ready_b", 32'(hreadyout_b), 32'd1);
      chk("rst_resp_b",  32'(hresp_b),     32'd0);
      @(negedge hclk); hresetn = 1'b1;
      @(posedge hclk); #1;

      // Directed table: one transfer per run, each followed by an idle gap.
      tbl.push_back(mk(1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 32'h0, 0));
      tbl.push_back(mk(0, 32'h10, 3'd2, 32'h0,        0, 32'hDEADBEEF, 0));
      tbl.push_back(mk(1, 32'h20, 3'd2, 32'h11223344, 0, 32'h0, 0));
      tbl.push_back(mk(1, 32'h21, 3'd0, 32'h0000AB00, 0, 32'h0, 0));
      tbl.push_back(mk(0, 32'h20, 3'd2, 32'h0,        0, 32'h1122AB44, 0));
      tbl.push_back(mk(1, 32'h00, 3'd2, 32'h0BADC0DE, 0, 32'h0, 0));
      tbl.push_back(mk(0, 32'(DEPTH_A*4), 3'd2, 32'h0, 1, 32'h0, 0));
      tbl.push_back(mk(1, 32'h03, 3'd1, 32'hFFFFFFFF, 1, 32'h0, 0));
      tbl.push_back(mk(0, 32'h00, 3'd2, 32'h0,        0, 32'h0BADC0DE, 0));
      tbl.push_back(mk(1, 32'h22, 3'd1, 32'h55660000, 0, 32'h0, 0));
      tbl.push_back(mk(0, 32'h21, 3'd0, 32'h0,        0, 32'h5566AB44, 0));
      tbl.push_back(mk(0, 32'h02, 3'd2, 32'h0,        1, 32'h0, 0));
      tbl.push_back(mk(0, 32'h00, 3'd3, 32'h0,        1, 32'h0, 0));
      tbl.push_back(mk(1, 32'h50, 3'd2, 32'h00000000, 0, 32'h0, 0));
      tbl.push_back(mk(1, 32'hFFFFFFFC, 3'd2, 32'h1,  1, 32'h0, 0));
      tbl.push_back(mk(0, 32'h00, 3'd2, 32'h0,        0, 32'h0BADC0DE, 0));
      for (int i = 0; i < tbl.size(); i++) begin
         xq.delete();
         xq.push_back(tbl[i]);
         run_q();
      end

      // Back-to-back write then read of the same word, no idle cycle.
      xq.delete();
      xq.push_back(mk(1, 32'h40, 3'd2, 32'hCAFEF00D, 0, 32'h0, 0));
      xq.push_back(mk(0, 32'h40, 3'd2, 32'h0,        0, 32'hCAFEF00D, 0));
      run_q();
      chk("b2b_total_cycles", 32'(total_cycles), 32'((WW_A + 1) + (RW_A + 1)));

      // Reset during the WAIT cycle of a write: response ends at once, no commit.
      drive_addr(mk(1, 32'h50, 3'd2, 32'h0, 0, 32'h0, 0));
      @(posedge hclk); #1;
      hwdata = 32'h12345678;
      drive_idle();
      @(negedge hclk);
      chk("wait_before_rst", 32'(hreadyout_a), 32'd0);
      #2 hresetn = 1'b0;
      #1;
      chk("rst_mid_wait_ready", 32'(hreadyout_a), 32'd1);
      chk("rst_mid_wait_resp",  32'(hresp_a),     32'd0);
      @(negedge hclk); hresetn = 1'b1;
      @(posedge hclk); #1;
      xq.delete();
      xq.push_back(mk(0, 32'h50, 3'd2, 32'h0, 0, 32'h0, 0));
      run_q();

      // Reset during ERR1.
      drive_addr(mk(0, 32'(DEPTH_A*4), 3'd2, 32'h0, 1, 32'h0, 0));
      @(posedge hclk); #1;
      drive_idle();
      @(negedge hclk);
      chk("err1_before_rst", 32'(hresp_a), 32'd1);
      #2 hresetn = 1'b0;
      #1;
      chk("rst_mid_err_resp",  32'(hresp_a),     32'd0);
      chk("rst_mid_err_ready", 32'(hreadyout_a), 32'd1);
      @(negedge hclk); hresetn = 1'b1;
      @(posedge hclk); #1;

      // Randomised back-to-back traffic on DUT A against the model.
      xq.delete();
      for (int j = 0; j < 8; j++)
         xq.push_back(mk(1, 32'h100 + 32'(4*j), 3'd2, $urandom, 0, 32'h0, 1));
      for (int j = 0; j < 60; j++) begin
         int          kind;
         logic [2:0]  s;
         logic [31:0] a;
         kind = $urandom_range(0, 8);
         s    = 3'($urandom_range(0, 2));
         a    = 32'h100 + 32'($urandom_range(0, 31));
         if (kind <= 5)      a = a & ~((32'd1 << s) - 32'd1);
         else if (kind == 6) s = 3'($urandom_range(3, 7));
         else if (kind == 7) begin s = 3'($urandom_range(1, 2)); a = a | 32'd1; end
         else                a = 32'(DEPTH_A*4) + 32'($urandom_range(0, 4095) * 4);
         xq.push_back(mk(1'($urandom_range(0, 1)), a, s, $urandom, 0, 32'h0, 1));
      end
      run_q();

      // Zero-wait instance: NONSEQ/SEQ/IDLE/BUSY/deselected mixed every cycle.
      begin
         bit          p_acc, p_wr;
         logic [31:0] p_a, wd, exp_rd;
         logic [2:0]  p_s, s;
         int          r;
         p_acc = 0; p_wr = 0; p_a = 0; p_s = 0;
         for (int i = 0; i < 240; i++) begin
            wd = $urandom;
            hwdata = wd;
            if (i < DEPTH_B) begin
               hsel_b = 1; htrans = 2'b10; hwrite = 1; hsize = 3'd2; haddr = 32'(i * 4);
            end else begin
               r = $urandom_range(0, 3);
               s = 3'($urandom_range(0, 2));
               hsize  = s;
               haddr  = 32'($urandom_range(0, DEPTH_B*4 - 1)) & ~((32'd1 << s) - 32'd1);
               hwrite = 1'($urandom_range(0, 1));
               case (r)
                  0:       begin hsel_b = 1; htrans = 2'($urandom_range(2, 3)); end
                  1:       begin hsel_b = 1; htrans = 2'b00; end
                  2:       begin hsel_b = 1; htrans = 2'b01; end
                  default: begin hsel_b = 0; htrans = 2'b10; end
               endcase
            end
            @(negedge hclk);
            exp_rd = (p_acc && !p_wr) ? mem_b[int'(p_a >> 2)] : 32'd0;
            chk("zw_ready", 32'(hreadyout_b), 32'd1);
            chk("zw_resp",  32'(hresp_b),     32'd0);
            chk("zw_rdata", hrdata_b,         exp_rd);
            @(posedge hclk);
            if (p_acc && p_wr) mem_b[int'(p_a >> 2)] = merge(mem_b[int'(p_a >> 2)], p_a, p_s, wd);
            p_acc = hsel_b && htrans[1];
            p_wr  = hwrite;
            p_a   = haddr;
            p_s   = hsize;
            #1;
         end
         drive_idle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
